fir_dec_sink: RTL and testbench
===============================

Name: fir_dec_sink

Overview:
- Receive-side companion to the team's 51-tap FIR low-pass.
- Consumes the filter's `d_out`/`valid` sample stream, discards pipeline-priming samples, and decimates by DEC.
- Buffers decimated samples in a small FIFO and presents them on a ready/valid master interface to downstream logic (capture RAM, UART framer).

Parameters:
- DATA_W, 16, sample width; must match the filter output width.
- DEC, 4, decimation factor, legal range 1..64.
- PRIME, 3, number of filter sample strobes discarded after reset/clr; covers the filter's z→temp→y pipeline.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, range 2..64.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush/restart, active-high, one cycle.
- in_valid  in  1  same strobe that drives the filter's `valid` input.
- in_data  in  DATA_W  filter `d_out`, signed.
- m_valid  out  1  FIFO head holds a sample.
- m_ready  in  1  downstream accepts the head this cycle.
- m_data  out  DATA_W  FIFO head sample, signed.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a decimated sample was dropped because the FIFO was full.

Behaviour:
- **Clock and reset:** one clock, `clk`. `reset` is asynchronous and active-high. While `reset` is high:
  - m_valid=0, m_data=0, fill=0, overflow=0.
  - Phase counter=0, prime counter=0, FSM=PRIME, FIFO pointers=0.
  - Reset mid-operation discards all FIFO contents immediately.
- **Sample strobe:** the filter updates `y` on the edge where valid=1, so the new value is visible one cycle later.
  - The block registers in_valid into s_stb (1-cycle delay).
  - in_data is sampled on cycles where s_stb=1.
  - in_data is never sampled on the in_valid cycle itself.
- **FSM:**
  - PRIME: each s_stb increments prime_cnt. On the PRIME-th s_stb, the sample is discarded, go to RUN, phase=0. PRIME=0 means enter RUN directly after reset.
  - RUN: each s_stb advances phase 0..DEC-1, wrapping to 0.
    - The sample at phase==0 becomes the decimated sample (push request).
    - Other phases are discarded.
    - DEC=1 pushes every strobe.
- **clr:** FIFO empty, overflow=0, phase=0, prime_cnt=0, FSM=PRIME, all on the next edge.
  - Any s_stb coinciding with clr is discarded.
  - clr has priority over push and pop in the same cycle.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the address.
  - full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - Pop when m_valid && m_ready.
  - Push when the push request is set and (!full, or pop in the same cycle). Full with simultaneous pop: both succeed, fill unchanged.
  - Push while full with no pop: sample dropped, overflow←1 (sticky until reset or clr), fill unchanged.
  - Empty with simultaneous push: no pop; m_valid rises on the next cycle (no fall-through).
- **Output handshake:**
  - m_valid = !empty; m_data = mem[rd_ptr] (head).
  - m_data is stable while m_valid && !m_ready.
  - m_ready while empty has no effect.
- **Latency:** the accepted sample appears on m_data/m_valid 2 cycles after the in_valid edge that produced it (1 cycle strobe delay + 1 cycle FIFO write).
- **Width:** data passes through unmodified (two's complement) in the default build.

Optional Feature:
- Macro: FIR_DEC_AVG_EN.
- **Defined:** boxcar-average decimation.
  - An accumulator of DATA_W+$clog2(DEC) bits, signed, sums all DEC strobes of a phase cycle.
  - On phase==DEC-1: the push value is the accumulator arithmetically shifted right by $clog2(DEC), truncated to DATA_W; the accumulator is then cleared.
  - DEC must be a power of 2; otherwise elaboration error via generate check.
  - The accumulator clears on reset, clr, and on entry to RUN.
  - Latency: measured from the strobe at phase DEC-1.
- **Undefined:** pick-every-DEC-th (sample at phase 0), no accumulator logic.

Test Plan:
- **Priming/decimation:** DEC=4, PRIME=3, m_ready=1; in_valid every 2nd cycle; the filter emulation supplies in_data one cycle after each strobe (stimulus ramp value = strobe index 0,1,2,…) → first three values dropped; m_data sequence 3,7,11,15; each m_valid pulse 2 cycles after the producing in_valid.
- **Full/overflow:** DEC=1, FIFO_DEPTH=8, m_ready=0, 10 strobes of values 0x0010..0x0019 after priming → fill=8, overflow=1 after the 9th; then draining with m_ready=1 yields 0x0010..0x0017 in order, then m_valid=0.
- **Simultaneous push/pop at full:** FIFO full (fill=8), m_ready=1 on the same cycle a decimated sample 0x7FFF is pushed → fill stays 8, overflow stays 0, 0x7FFF is emitted last.
- **clr mid-stream:** clr asserted with fill=5 and phase=2, with an s_stb on the same cycle → next cycle fill=0, m_valid=0, overflow=0; the next 3 strobes are discarded (PRIME again).
- **Async reset:** reset asserted mid-cycle between edges while m_valid=1 → m_valid, m_data, fill, overflow go to 0 immediately without a clock edge.
- **FIR_DEC_AVG_EN:** DEC=4, inputs -4,-4,-4,-3 (0xFFFC…0xFFFD) → output -4 (0xFFFC, arithmetic shift rounds toward -inf); inputs 0x7FFF×4 → 0x7FFF, no overflow.

Source files
------------

// File: rtl/fir_dec_sink.sv
// Receive-side sink for the 51-tap FIR: drops priming samples, decimates by DEC, buffers in a FIFO.
// Define FIR_DEC_AVG_EN to replace pick-every-DEC-th with boxcar-average decimation.
module fir_dec_sink #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEC        = 4,
    parameter int unsigned PRIME      = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic signed [DATA_W-1:0]       in_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic signed [DATA_W-1:0]       m_data,
    output logic [$clog2(FIFO_DEPTH):0]    fill,
    output logic                           overflow
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PH_W = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int unsigned PC_W = (PRIME > 0) ? $clog2(PRIME + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRIME - 1);

    typedef enum logic [0:0] {StPrime, StRun} state_t;
    localparam state_t ST_INIT = (PRIME == 0) ? StRun : StPrime;

    state_t                   state_q;
    logic                     s_stb_q;
    logic [PH_W-1:0]          phase_q;
    logic [PC_W-1:0]          prime_cnt_q;
    logic [AW:0]              wr_ptr_q, rd_ptr_q;
    logic                     overflow_q;
    logic signed [DATA_W-1:0] mem [FIFO_DEPTH];

    logic                     strobe, push_req, push, pop, empty, full;
    logic signed [DATA_W-1:0] push_data;

    assign strobe = s_stb_q && !clr;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && m_ready && !clr;
    assign push   = push_req && (!full || pop);

`ifdef FIR_DEC_AVG_EN
    localparam int unsigned LOG   = $clog2(DEC);
    localparam int unsigned ACC_W = DATA_W + LOG;

    if ((DEC & (DEC - 1)) != 0) begin : g_dec_pow2_check
        $error("fir_dec_sink: DEC must be a power of 2 when averaging");
    end

    logic signed [ACC_W-1:0] acc_q, acc_sum, acc_shift;

    assign acc_sum   = acc_q + ACC_W'(in_data);
    assign acc_shift = acc_sum >>> LOG;
    assign push_req  = strobe && (state_q == StRun) && (phase_q == PH_LAST);
    assign push_data = acc_shift[DATA_W-1:0];
`else
    assign push_req  = strobe && (state_q == StRun) && (phase_q == '0);
    assign push_data = in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_stb_q     <= 1'b0;
            state_q     <= ST_INIT;
            phase_q     <= '0;
            prime_cnt_q <= '0;
`ifdef FIR_DEC_AVG_EN
            acc_q       <= '0;
`endif
        end else begin
            s_stb_q <= in_valid;
            if (clr) begin
                state_q     <= ST_INIT;
                phase_q     <= '0;
                prime_cnt_q <= '0;
`ifdef FIR_DEC_AVG_EN
                acc_q       <= '0;
`endif
            end else if (s_stb_q) begin
                case (state_q)
                    StPrime: begin
                        prime_cnt_q <= prime_cnt_q + 1'b1;
                        if (prime_cnt_q == PC_LAST) begin
                            state_q <= StRun;
                            phase_q <= '0;
`ifdef FIR_DEC_AVG_EN
                            acc_q   <= '0;
`endif
                        end
                    end
                    StRun: begin
                        phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
`ifdef FIR_DEC_AVG_EN
                        acc_q   <= (phase_q == PH_LAST) ? '0 : acc_sum;
`endif
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_req && !push) overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; m_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign m_valid  = !empty;
    assign m_data   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_dec_sink.sv
// Scoreboard bench for fir_dec_sink (DEC=4, PRIME=3, FIFO_DEPTH=8) with directed vectors.
module tb_fir_dec_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  fill;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

`ifdef FIR_DEC_AVG_EN
    localparam int PUSH_J = 3;
`else
    localparam int PUSH_J = 0;
`endif

    always #5 clk = ~clk;

    fir_dec_sink #(
        .DATA_W(16),
        .DEC(4),
        .PRIME(3),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .in_valid(in_valid),
        .in_data(in_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .fill(fill),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head is compared against the oldest expected sample.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h want none", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("m_data", {16'h0, m_data}, {16'h0, mon_exp});
            end
        end
    end

    // Filter emulation: strobe cycle, then the new y value appears one cycle later.
    task automatic strobe_x(input logic [15:0] v, input logic rdy, input logic c);
        logic saved;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = v;
        saved    = m_ready;
        m_ready  = rdy;
        clr      = c;
        @(posedge clk); #1;
        m_ready  = saved;
        clr      = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] v);
        strobe_x(v, m_ready, 1'b0);
    endtask

    // Four equal strobes: pick and average modes both yield v.
    task automatic group(input logic [15:0] v);
        for (int j = 0; j < 4; j++) strobe(v);
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!m_valid && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check({name, "_m_valid"}, {31'h0, m_valid}, 32'h0);
        check({name, "_pending"}, exp_q.size(), 32'h0);
        m_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_m_valid", {31'h0, m_valid}, 32'h0);
        check("rst_m_data", {16'h0, m_data}, 32'h0);
        check("rst_fill", {28'h0, fill}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Priming and decimation on a ramp
        m_ready = 1'b1;
`ifdef FIR_DEC_AVG_EN
        exp_q.push_back(16'd4); exp_q.push_back(16'd8);
        exp_q.push_back(16'd12); exp_q.push_back(16'd16);
`else
        exp_q.push_back(16'd3); exp_q.push_back(16'd7);
        exp_q.push_back(16'd11); exp_q.push_back(16'd15);
`endif
        for (int k = 0; k < 19; k++) begin
`ifndef FIR_DEC_AVG_EN
            if (k == 3) begin
                in_valid = 1'b1;
                @(posedge clk); #1;
                check("lat_m_valid_early", {31'h0, m_valid}, 32'h0);
                in_valid = 1'b0;
                in_data  = 16'd3;
                @(posedge clk); #1;
                check("lat_m_valid", {31'h0, m_valid}, 32'h1);
                check("lat_fill", {28'h0, fill}, 32'h1);
                continue;
            end
`endif
            strobe(16'(k));
        end
        drain("prime");

        // Fill to full, then overflow
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0010 + 16'(i));
        for (int i = 0; i < 10; i++) begin
            group(16'h0010 + 16'(i));
            if (i == 7) begin
                check("full_fill", {28'h0, fill}, 32'h8);
                check("full_overflow", {31'h0, overflow}, 32'h0);
            end
            if (i == 8) begin
                check("ovf_overflow", {31'h0, overflow}, 32'h1);
                check("ovf_fill", {28'h0, fill}, 32'h8);
            end
        end
        drain("ovf");
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        // clr mid-stream with a coinciding strobe
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) group(16'h0030 + 16'(i));
        strobe(16'h0035);
        strobe(16'h0035);
`ifndef FIR_DEC_AVG_EN
        check("clr_pre_fill", {28'h0, fill}, 32'h5);
`endif
        strobe_x(16'h0036, 1'b0, 1'b1);
        check("clr_fill", {28'h0, fill}, 32'h0);
        check("clr_m_valid", {31'h0, m_valid}, 32'h0);
        check("clr_overflow", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 3; i++) strobe(16'h0055);
        m_ready = 1'b1;
        exp_q.push_back(16'h0040);
        group(16'h0040);
        drain("clr");

        // Simultaneous push and pop while full
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0020 + 16'(i));
        exp_q.push_back(16'h7FFF);
        for (int i = 0; i < 8; i++) group(16'h0020 + 16'(i));
        check("pp_full_fill", {28'h0, fill}, 32'h8);
        for (int j = 0; j < 4; j++) strobe_x(16'h7FFF, (j == PUSH_J), 1'b0);
        check("pp_fill", {28'h0, fill}, 32'h8);
        check("pp_overflow", {31'h0, overflow}, 32'h0);
        drain("pp");

        // Asynchronous reset between edges
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) group(16'h0060 + 16'(i));
        check("ar_pre_overflow", {31'h0, overflow}, 32'h1);
        check("ar_pre_m_valid", {31'h0, m_valid}, 32'h1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("ar_m_valid", {31'h0, m_valid}, 32'h0);
        check("ar_m_data", {16'h0, m_data}, 32'h0);
        check("ar_fill", {28'h0, fill}, 32'h0);
        check("ar_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) strobe(16'h0000);
        m_ready = 1'b1;
        exp_q.push_back(16'h0077);
        group(16'h0077);
        drain("ar");

`ifdef FIR_DEC_AVG_EN
        // Boxcar average: floor rounding and full-scale positive
        m_ready = 1'b1;
        exp_q.push_back(16'hFFFC);
        exp_q.push_back(16'h7FFF);
        strobe(16'hFFFC); strobe(16'hFFFC); strobe(16'hFFFC); strobe(16'hFFFD);
        group(16'h7FFF);
        drain("avg");
        check("avg_overflow", {31'h0, overflow}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
